arbitro_escritura_banco: RTL and testbench
==========================================

// Module: arbitro_escritura_banco
// PURPOSE
//  Shares the single write port of the 8x16-bit register bank (Banco8Registros16Bit) between two requesters:
//  A = ALU writeback, B = load writeback.
//  Each requester has a one-entry holding buffer with a valid/ready handshake.
//  A round-robin arbiter drains the buffers into registered bank-write outputs.
//  A per-register pending mask lets the decoder stall on reads of registers not yet written.
// PARAMETERS
//  ANCHO_DATO  16  data width of a register
//  ANCHO_DIR   3   register address width
//  NUM_REG     8   register count, must equal 2**ANCHO_DIR
// PORTS
//  Reloj               in   1           clock, rising edge
//  Reiniciar           in   1           synchronous reset, active high
//  SolA_Valido         in   1           requester A offers a write
//  SolA_Listo          out  1           A buffer can accept this cycle
//  SolA_Dato           in   ANCHO_DATO  A write data
//  SolA_Dir            in   ANCHO_DIR   A target register
//  SolB_Valido/Listo/Dato/Dir           same as A, for requester B
//  Habilitar           out  1           bank write enable (registered)
//  Tupla               out  ANCHO_DATO  bank write data (registered)
//  DireccionEscritura  out  ANCHO_DIR   bank write address (registered)
//  Pendiente           out  NUM_REG     bit i=1: a write to register i is not yet in the bank
// BEHAVIOUR
//  Reset: buffers empty, Habilitar=0, Tupla=0, DireccionEscritura=0, priority pointer=A.
//   SolA_Listo and SolB_Listo are 0 while Reiniciar=1.
//  Per-buffer state: VACIO/LLENO.
//   Accept on edge when Valido&&Listo: capture Dato/Dir, go to LLENO.
//   Valido without Listo: the requester must hold Valido, Dato and Dir stable.
//  Listo = ~Reiniciar & (VACIO | buffer granted this cycle).
//   A granted buffer reloads on the same edge, so full throughput.
//  Grant decision is combinational from state only (no Valido->Listo path):
//   only A full -> A; only B full -> B.
//   Both full -> the side the pointer names; the pointer then flips to the other side.
//   The pointer changes only on a two-way contention grant.
//  On a grant edge: Habilitar<=1, Tupla/DireccionEscritura <= winner buffer; winner buffer empties.
//   No grant -> Habilitar<=0; Tupla/DireccionEscritura hold.
//  Latency: accepted at edge n -> outputs valid after edge n+1 (uncontended) -> bank captures at edge n+2.
//   Contended loser adds one cycle.
//  Pendiente[i] = (A LLENO & A.Dir==i) | (B LLENO & B.Dir==i) | (Habilitar & DireccionEscritura==i).
//   Combinational from state.
//  Same address from A and B: the later grant overwrites. No cross-requester ordering is guaranteed.
//   Within one requester, order is preserved.
//  Reset mid-operation: buffered and output-register writes are discarded.
//   Habilitar=0 after the reset edge, Pendiente=0.
// CONFIGURATION
//  ARB_R0_CERO_EN defined:
//   register 0 is hard zero; the handshake is unchanged.
//   A granted buffer with Dir==0 empties without asserting Habilitar.
//   Such an entry never sets Pendiente[0]; Pendiente[0] is constant 0.
//  ARB_R0_CERO_EN undefined: address 0 is handled like any other.
// STRUCTURE
//  Package banco_pkg:
//   ANCHO_DATO, ANCHO_DIR, NUM_REG
//   requester ids ID_A=1'b0, ID_B=1'b1
//   buffer state encoding VACIO=1'b0, LLENO=1'b1
//  Sub-module buffer_solicitud: one-entry holding buffer (state, Dato, Dir, Listo).
//   Instantiated twice; the arbiter, output registers and Pendiente logic live in the top.
// TESTING (bench instantiates this block driving Banco8Registros16Bit)
//  1. Reiniciar=1 for 2 cycles -> Habilitar=0, Tupla=16'h0, both Listo=0; first cycle after release both Listo=1.
//  2. A only: 16'h00A5 to 3'b111 at edge n -> after n+1 Habilitar=1, Dir=7, Tupla=00A5;
//     Pendiente[7]=1 until after n+2; bank read port at 3'b111 returns 00A5.
//  3. A (Dir 4, 16'h1111) and B (Dir 5, 16'h2222) held valid continuously ->
//     Habilitar stays 1, grants alternate A,B,A,B; each Listo toggles 1,0,1,0.
//  4. A and B both write Dir 3 simultaneously, pointer=A: A=16'hAAAA, B=16'hBBBB ->
//     A written first, then B; register 3 ends 16'hBBBB; Pendiente[3] clears after B lands.
//  5. Both buffers full and Habilitar=1, then Reiniciar=1 for 1 cycle ->
//     next cycle Habilitar=0, Pendiente=8'h00, bank contents unchanged.
//  6. A writes 16'hFFFF to Dir 0:
//     with ARB_R0_CERO_EN -> Habilitar never 1, SolA_Listo high again next cycle, Pendiente[0]=0;
//     without it -> Habilitar=1, DireccionEscritura=0, Tupla=FFFF.

Source files
------------

// File: rtl/banco_pkg.sv
// ---------------------------------------------------------------------------
// banco_pkg
// Shared definitions for the register-bank write arbiter.
//   ANCHO_DATO / ANCHO_DIR / NUM_REG : default bank geometry (8 x 16 bit)
//   id_sol_t                         : requester identity (A = ALU, B = load)
//   estado_buf_t                     : one-entry holding buffer state
// ---------------------------------------------------------------------------
package banco_pkg;

  localparam int ANCHO_DATO = 16;
  localparam int ANCHO_DIR  = 3;
  localparam int NUM_REG    = 8;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } id_sol_t;

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_buf_t;

  function automatic id_sol_t otro_lado(input id_sol_t id);
    return (id == ID_A) ? ID_B : ID_A;
  endfunction

endpackage

// File: rtl/buffer_solicitud.sv
// ---------------------------------------------------------------------------
// buffer_solicitud
// One-entry holding buffer with a valid/ready handshake on the input side.
// The arbiter drains it through 'concedido'; a granted buffer may reload on
// the same edge, so a continuously valid requester sustains one write per
// cycle whenever it wins.
//
// Ports
//   reloj, reiniciar   clock, synchronous active-high reset
//   valido, listo      requester handshake (listo is 0 during reset)
//   dato, dir          requester payload, captured when valido && listo
//   concedido          arbiter takes the held entry this cycle
//   lleno              buffer holds an entry
//   dato_buf, dir_buf  held entry
//
// state | meaning
// ------+------------------------------------------------
// VACIO | no entry held, ready to accept
// LLENO | entry held, waiting for a grant from the arbiter
// ---------------------------------------------------------------------------
module buffer_solicitud
  import banco_pkg::*;
#(
  parameter int ANCHO_DATO = banco_pkg::ANCHO_DATO,
  parameter int ANCHO_DIR  = banco_pkg::ANCHO_DIR
) (
  input  logic                  reloj,
  input  logic                  reiniciar,
  input  logic                  valido,
  output logic                  listo,
  input  logic [ANCHO_DATO-1:0] dato,
  input  logic [ANCHO_DIR-1:0]  dir,
  input  logic                  concedido,
  output logic                  lleno,
  output logic [ANCHO_DATO-1:0] dato_buf,
  output logic [ANCHO_DIR-1:0]  dir_buf
);

  estado_buf_t           estado_q;
  estado_buf_t           estado_d;
  logic                  acepta;
  logic [ANCHO_DATO-1:0] dato_q;
  logic [ANCHO_DIR-1:0]  dir_q;

  // listo depends only on state, grant and reset: no valido -> listo path.
  always_comb begin
    listo    = ~reiniciar & ((estado_q == VACIO) | concedido);
    acepta   = valido & listo;
    estado_d = estado_q;
    case (estado_q)
      VACIO: if (acepta) estado_d = LLENO;
      LLENO: if (concedido && !acepta) estado_d = VACIO;
      default: estado_d = VACIO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reiniciar) begin
      estado_q <= VACIO;
      dato_q   <= '0;
      dir_q    <= '0;
    end else begin
      estado_q <= estado_d;
      if (acepta) begin
        dato_q <= dato;
        dir_q  <= dir;
      end
    end
  end

  assign lleno    = (estado_q == LLENO);
  assign dato_buf = dato_q;
  assign dir_buf  = dir_q;

endmodule

// File: rtl/arbitro_escritura_banco.sv
// ---------------------------------------------------------------------------
// arbitro_escritura_banco
// Shares the single write port of the 8x16-bit register bank between the
// ALU writeback (requester A) and the load writeback (requester B).
// Each requester feeds a one-entry buffer; a round-robin arbiter drains the
// buffers into registered bank-write outputs, and a per-register pending
// mask lets the decoder stall on reads of registers still in flight.
//
// Ports
//   Reloj, Reiniciar                 clock, synchronous active-high reset
//   SolA_Valido/Listo/Dato/Dir       requester A handshake and payload
//   SolB_Valido/Listo/Dato/Dir       requester B handshake and payload
//   Habilitar                        bank write enable (registered)
//   Tupla                            bank write data (registered)
//   DireccionEscritura               bank write address (registered)
//   Pendiente                        bit i: a write to register i not yet
//                                    in the bank
//
// Build option
//   ARB_R0_CERO_EN  register 0 is hard zero: a granted entry addressed to 0
//                   is dropped without raising Habilitar, and Pendiente[0]
//                   is constant 0. Undefined: address 0 is ordinary.
//
// NUM_REG must equal 2**ANCHO_DIR.
// ---------------------------------------------------------------------------
module arbitro_escritura_banco
  import banco_pkg::*;
#(
  parameter int ANCHO_DATO = banco_pkg::ANCHO_DATO,
  parameter int ANCHO_DIR  = banco_pkg::ANCHO_DIR,
  parameter int NUM_REG    = banco_pkg::NUM_REG
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic                  SolA_Valido,
  output logic                  SolA_Listo,
  input  logic [ANCHO_DATO-1:0] SolA_Dato,
  input  logic [ANCHO_DIR-1:0]  SolA_Dir,
  input  logic                  SolB_Valido,
  output logic                  SolB_Listo,
  input  logic [ANCHO_DATO-1:0] SolB_Dato,
  input  logic [ANCHO_DIR-1:0]  SolB_Dir,
  output logic                  Habilitar,
  output logic [ANCHO_DATO-1:0] Tupla,
  output logic [ANCHO_DIR-1:0]  DireccionEscritura,
  output logic [NUM_REG-1:0]    Pendiente
);

  logic                  lleno_a;
  logic                  lleno_b;
  logic [ANCHO_DATO-1:0] dato_a;
  logic [ANCHO_DATO-1:0] dato_b;
  logic [ANCHO_DIR-1:0]  dir_a;
  logic [ANCHO_DIR-1:0]  dir_b;

  logic                  hay_conc;
  logic                  contienda;
  id_sol_t               ganador;
  logic                  conc_a;
  logic                  conc_b;
  logic [ANCHO_DATO-1:0] dato_gan;
  logic [ANCHO_DIR-1:0]  dir_gan;
  logic                  escribe;
  id_sol_t               puntero_q;

  buffer_solicitud #(
    .ANCHO_DATO (ANCHO_DATO),
    .ANCHO_DIR  (ANCHO_DIR)
  ) u_buf_a (
    .reloj     (Reloj),
    .reiniciar (Reiniciar),
    .valido    (SolA_Valido),
    .listo     (SolA_Listo),
    .dato      (SolA_Dato),
    .dir       (SolA_Dir),
    .concedido (conc_a),
    .lleno     (lleno_a),
    .dato_buf  (dato_a),
    .dir_buf   (dir_a)
  );

  buffer_solicitud #(
    .ANCHO_DATO (ANCHO_DATO),
    .ANCHO_DIR  (ANCHO_DIR)
  ) u_buf_b (
    .reloj     (Reloj),
    .reiniciar (Reiniciar),
    .valido    (SolB_Valido),
    .listo     (SolB_Listo),
    .dato      (SolB_Dato),
    .dir       (SolB_Dir),
    .concedido (conc_b),
    .lleno     (lleno_b),
    .dato_buf  (dato_b),
    .dir_buf   (dir_b)
  );

  // Grant is a function of buffer state and pointer only, so the listo
  // outputs never see the requesters' valido.
  always_comb begin
    hay_conc  = lleno_a | lleno_b;
    contienda = lleno_a & lleno_b;
    if (contienda)    ganador = puntero_q;
    else if (lleno_a) ganador = ID_A;
    else              ganador = ID_B;
    conc_a   = hay_conc & (ganador == ID_A);
    conc_b   = hay_conc & (ganador == ID_B);
    dato_gan = (ganador == ID_A) ? dato_a : dato_b;
    dir_gan  = (ganador == ID_A) ? dir_a  : dir_b;
`ifdef ARB_R0_CERO_EN
    // Writes to the hard-zero register are consumed but never reach the bank.
    escribe  = hay_conc & (dir_gan != '0);
`else
    escribe  = hay_conc;
`endif
  end

  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      Habilitar          <= 1'b0;
      Tupla              <= '0;
      DireccionEscritura <= '0;
      puntero_q          <= ID_A;
    end else begin
      Habilitar <= escribe;
      if (escribe) begin
        Tupla              <= dato_gan;
        DireccionEscritura <= dir_gan;
      end
      // Only a two-way contention moves the pointer, so a lone requester
      // never steals the other's next turn.
      if (contienda) puntero_q <= otro_lado(puntero_q);
    end
  end

  always_comb begin
    Pendiente = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if ((lleno_a   && (dir_a == ANCHO_DIR'(i))) ||
          (lleno_b   && (dir_b == ANCHO_DIR'(i))) ||
          (Habilitar && (DireccionEscritura == ANCHO_DIR'(i))))
        Pendiente[i] = 1'b1;
    end
`ifdef ARB_R0_CERO_EN
    Pendiente[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// ---------------------------------------------------------------------------
// tb_arbitro_escritura_banco
// Directed bench for the register-bank write arbiter. A small behavioural
// 8x16 bank sits on the arbiter's write port; its write is qualified by the
// shared reset so an in-flight output-register write is dropped on reset.
// Inputs change on falling edges; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_arbitro_escritura_banco;

  logic        Reloj;
  logic        Reiniciar;
  logic        SolA_Valido;
  logic        SolA_Listo;
  logic [15:0] SolA_Dato;
  logic [2:0]  SolA_Dir;
  logic        SolB_Valido;
  logic        SolB_Listo;
  logic [15:0] SolB_Dato;
  logic [2:0]  SolB_Dir;
  logic        Habilitar;
  logic [15:0] Tupla;
  logic [2:0]  DireccionEscritura;
  logic [7:0]  Pendiente;

  logic [15:0] banco [8];
  logic        limpiar_banco;

  int total = 0;
  int malos = 0;

  arbitro_escritura_banco dut (
    .Reloj              (Reloj),
    .Reiniciar          (Reiniciar),
    .SolA_Valido        (SolA_Valido),
    .SolA_Listo         (SolA_Listo),
    .SolA_Dato          (SolA_Dato),
    .SolA_Dir           (SolA_Dir),
    .SolB_Valido        (SolB_Valido),
    .SolB_Listo         (SolB_Listo),
    .SolB_Dato          (SolB_Dato),
    .SolB_Dir           (SolB_Dir),
    .Habilitar          (Habilitar),
    .Tupla              (Tupla),
    .DireccionEscritura (DireccionEscritura),
    .Pendiente          (Pendiente)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  always @(posedge Reloj) begin
    if (limpiar_banco) begin
      for (int i = 0; i < 8; i++) banco[i] <= 16'h0;
    end else if (Habilitar && !Reiniciar) begin
      banco[DireccionEscritura] <= Tupla;
    end
  end

  task automatic comprobar(input string etiqueta, input logic [31:0] obs,
                           input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      malos++;
      $display("FAIL %s: got %0h expected %0h", etiqueta, obs, esp);
    end
  endtask

  task automatic bajada();
    @(negedge Reloj);
  endtask

  initial begin
    Reiniciar     = 1'b1;
    limpiar_banco = 1'b1;
    SolA_Valido   = 1'b0;
    SolA_Dato     = 16'h0;
    SolA_Dir      = 3'd0;
    SolB_Valido   = 1'b0;
    SolB_Dato     = 16'h0;
    SolB_Dir      = 3'd0;

    // 1. reset for two edges
    bajada();
    bajada();
    comprobar("rst_hab",    Habilitar,  1'b0);
    comprobar("rst_tupla",  Tupla,      16'h0);
    comprobar("rst_listoa", SolA_Listo, 1'b0);
    comprobar("rst_listob", SolB_Listo, 1'b0);
    comprobar("rst_pend",   Pendiente,  8'h00);
    Reiniciar     = 1'b0;
    limpiar_banco = 1'b0;
    #1;
    comprobar("rel_listoa", SolA_Listo, 1'b1);
    comprobar("rel_listob", SolB_Listo, 1'b1);

    // 2. A alone: 00A5 -> r7
    SolA_Valido = 1'b1; SolA_Dato = 16'h00A5; SolA_Dir = 3'd7;
    bajada();
    SolA_Valido = 1'b0;
    comprobar("a_hab_n",    Habilitar,    1'b0);
    comprobar("a_pend7_n",  Pendiente[7], 1'b1);
    bajada();
    comprobar("a_hab",      Habilitar,          1'b1);
    comprobar("a_dir",      DireccionEscritura, 3'd7);
    comprobar("a_tupla",    Tupla,              16'h00A5);
    comprobar("a_pend",     Pendiente,          8'h80);
    bajada();
    comprobar("a_hab_fin",  Habilitar, 1'b0);
    comprobar("a_pend_fin", Pendiente, 8'h00);
    comprobar("a_banco7",   banco[7],  16'h00A5);

    // 3. A and B held valid: alternate A,B,A
    SolA_Valido = 1'b1; SolA_Dato = 16'h1111; SolA_Dir = 3'd4;
    SolB_Valido = 1'b1; SolB_Dato = 16'h2222; SolB_Dir = 3'd5;
    bajada();
    comprobar("rr_listoa0", SolA_Listo, 1'b1);
    comprobar("rr_listob0", SolB_Listo, 1'b0);
    comprobar("rr_pend0",   Pendiente,  8'h30);
    for (int k = 0; k < 3; k++) begin
      bajada();
      comprobar("rr_hab",    Habilitar, 1'b1);
      comprobar("rr_dir",    DireccionEscritura, (k % 2 == 0) ? 3'd4 : 3'd5);
      comprobar("rr_tupla",  Tupla, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      comprobar("rr_listoa", SolA_Listo, (k % 2 == 0) ? 1'b0 : 1'b1);
      comprobar("rr_listob", SolB_Listo, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    SolA_Valido = 1'b0;
    SolB_Valido = 1'b0;
    bajada();
    comprobar("rr_drain_b", DireccionEscritura, 3'd5);
    bajada();
    comprobar("rr_drain_a", DireccionEscritura, 3'd4);
    comprobar("rr_drain_h", Habilitar, 1'b1);
    bajada();
    comprobar("rr_fin_hab", Habilitar, 1'b0);
    comprobar("rr_fin_pnd", Pendiente, 8'h00);
    comprobar("rr_banco4",  banco[4],  16'h1111);
    comprobar("rr_banco5",  banco[5],  16'h2222);

    // 4. same address from both, pointer at A
    SolA_Valido = 1'b1; SolA_Dato = 16'hAAAA; SolA_Dir = 3'd3;
    SolB_Valido = 1'b1; SolB_Dato = 16'hBBBB; SolB_Dir = 3'd3;
    bajada();
    SolA_Valido = 1'b0;
    SolB_Valido = 1'b0;
    comprobar("dup_pend",    Pendiente, 8'h08);
    bajada();
    comprobar("dup_tupla1",  Tupla,     16'hAAAA);
    comprobar("dup_dir1",    DireccionEscritura, 3'd3);
    bajada();
    comprobar("dup_tupla2",  Tupla,     16'hBBBB);
    comprobar("dup_banco_a", banco[3],  16'hAAAA);
    comprobar("dup_pend2",   Pendiente, 8'h08);
    bajada();
    comprobar("dup_pend3",   Pendiente, 8'h00);
    comprobar("dup_banco_b", banco[3],  16'hBBBB);

    // 5. reset while both buffers full and a write is in the output register
    SolA_Valido = 1'b1; SolA_Dato = 16'h1234; SolA_Dir = 3'd1;
    SolB_Valido = 1'b1; SolB_Dato = 16'h5678; SolB_Dir = 3'd2;
    bajada();
    bajada();
    comprobar("rm_hab",  Habilitar,          1'b1);
    comprobar("rm_dir",  DireccionEscritura, 3'd2);
    comprobar("rm_pend", Pendiente,          8'h06);
    Reiniciar   = 1'b1;
    SolA_Valido = 1'b0;
    SolB_Valido = 1'b0;
    bajada();
    Reiniciar = 1'b0;
    comprobar("rm_hab0",   Habilitar, 1'b0);
    comprobar("rm_pend0",  Pendiente, 8'h00);
    comprobar("rm_banco1", banco[1],  16'h0);
    comprobar("rm_banco2", banco[2],  16'h0);
    comprobar("rm_banco3", banco[3],  16'hBBBB);
    #1;
    comprobar("rm_listoa", SolA_Listo, 1'b1);

    // 6. A writes FFFF to r0
    SolA_Valido = 1'b1; SolA_Dato = 16'hFFFF; SolA_Dir = 3'd0;
    bajada();
    SolA_Valido = 1'b0;
`ifdef ARB_R0_CERO_EN
    comprobar("r0_pend_n", Pendiente, 8'h00);
    bajada();
    comprobar("r0_hab",    Habilitar,  1'b0);
    comprobar("r0_listoa", SolA_Listo, 1'b1);
    comprobar("r0_pend",   Pendiente,  8'h00);
    bajada();
    comprobar("r0_hab2",   Habilitar, 1'b0);
    comprobar("r0_banco0", banco[0],  16'h0);
`else
    comprobar("r0_pend_n", Pendiente, 8'h01);
    bajada();
    comprobar("r0_hab",    Habilitar,          1'b1);
    comprobar("r0_dir",    DireccionEscritura, 3'd0);
    comprobar("r0_tupla",  Tupla,              16'hFFFF);
    comprobar("r0_listoa", SolA_Listo,         1'b1);
    bajada();
    comprobar("r0_hab2",   Habilitar, 1'b0);
    comprobar("r0_banco0", banco[0],  16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, malos);
    $finish;
  end

endmodule
